nn_neuron_seq: RTL

Wishbone-attached single-neuron compute engine for the trainable NN user project; it is the stage behind the user-area Wishbone decode that the management SoC drives. Firmware loads N signed weights, N signed inputs and a bias, then writes START. The block runs a sequential multiply-accumulate of one product per cycle, shifts and clamps the sum, and raises done, busy and irq. It also exports the result to the logic analyzer.

---
 rtl/nn_pkg.sv | 23 ++
 rtl/nn_mac.sv | 45 ++++
 rtl/nn_neuron_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared FSM state, register offsets and saturation helper for nn_neuron_seq
package nn_pkg;

    typedef enum logic [1:0] {IDLE, MAC, FINISH} state_e;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_BIAS   = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_ACC    = 8'h10;
    localparam logic [1:0] REG_WEIGHT = 2'b01;
    localparam logic [1:0] REG_INPUT  = 2'b10;

    // Clamp v to a signed w-bit range; with relu the lower bound becomes 0.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w, input logic relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = relu ? 64'sd0 : -(64'sd1 <<< (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/nn_mac.sv
// nn_mac: sequential signed multiply-accumulate with index counter
// Ports: clk_i/rst_i clock and async reset; load_i loads bias and clears idx;
// step_i adds w_i*x_i and advances idx; acc_o accumulator; idx_o current pair; last_o idx at final pair.
module nn_mac #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_i,
    input  logic                          step_i,
    input  logic signed [DATA_W-1:0]      bias_i,
    input  logic signed [DATA_W-1:0]      w_i,
    input  logic signed [DATA_W-1:0]      x_i,
    output logic signed [ACC_W-1:0]       acc_o,
    output logic [$clog2(N_INPUTS)-1:0]   idx_o,
    output logic                          last_o
);
    localparam int IW = $clog2(N_INPUTS);

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic signed [2*DATA_W-1:0] prod;

    assign acc_o  = acc_q;
    assign idx_o  = idx_q;
    assign last_o = idx_q == IW'(N_INPUTS - 1);

    always_comb begin
        prod  = (2*DATA_W)'(w_i) * (2*DATA_W)'(x_i);
        acc_d = load_i ? ACC_W'(bias_i) : step_i ? acc_q + ACC_W'(prod) : acc_q;
        idx_d = load_i ? '0 : step_i ? (last_o ? '0 : idx_q + IW'(1)) : idx_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/nn_neuron_seq.sv
// nn_neuron_seq: Wishbone-attached single-neuron MAC engine with clamp, done/irq and LA result export
// Ports: wb_clk_i/wb_rst_i clock and async reset; wbs_* Wishbone slave; irq_o done&IRQ_EN;
// busy_o MAC/FINISH in progress; result_o last clamped result.
// Build option: define NN_RELU_EN to clamp with ReLU instead of signed saturation.
module nn_neuron_seq
    import nn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          N_INPUTS  = 8,
    parameter int          DATA_W    = 8,
    parameter int          ACC_W     = 20,
    parameter int          SHIFT     = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              irq_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] result_o
);
    localparam int IW = $clog2(N_INPUTS);
`ifdef NN_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    state_e                  state_q;
    logic                    ack_q, start_q, irq_en_q, done_q;
    logic [31:0]             dat_q, rdata;
    logic signed [DATA_W-1:0] bias_q, result_q;
    logic signed [DATA_W-1:0] w_q [N_INPUTS];
    logic signed [DATA_W-1:0] x_q [N_INPUTS];
    logic signed [ACC_W-1:0] acc;
    logic [IW-1:0]           idx, wi;
    logic [7:0]              off;
    logic                    hit, valid, wr, lock, in_rng, last;
    logic                    unused_ok;

    assign off       = wbs_adr_i[7:0];
    assign wi        = wbs_adr_i[IW+1:2];
    assign hit       = wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign valid     = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign wr        = valid && wbs_we_i && wbs_sel_i[0] && hit;
    assign in_rng    = {28'd0, wbs_adr_i[5:2]} < 32'(N_INPUTS);
    // A START already accepted but not yet acted on counts as busy for write locking.
    assign lock      = (state_q != IDLE) || start_q;
    assign busy_o    = state_q != IDLE;
    assign irq_o     = done_q && irq_en_q;
    assign result_o  = result_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i[31:DATA_W], wbs_adr_i[1:0]};

    always_comb begin
        rdata = !hit ? 32'd0 :
                (off == OFF_CTRL)   ? {30'd0, irq_en_q, 1'b0} :
                (off == OFF_STATUS) ? {30'd0, done_q, busy_o} :
                (off == OFF_BIAS)   ? 32'(bias_q) :
                (off == OFF_RESULT) ? 32'(result_q) :
                (off == OFF_ACC)    ? 32'(acc) :
                (off[7:6] == REG_WEIGHT && in_rng) ? 32'(w_q[wi]) :
                (off[7:6] == REG_INPUT && in_rng)  ? 32'(x_q[wi]) : 32'd0;
    end

    nn_mac #(.N_INPUTS(N_INPUTS), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .load_i (state_q == IDLE && start_q),
        .step_i (state_q == MAC),
        .bias_i (bias_q),
        .w_i    (w_q[idx]),
        .x_i    (x_q[idx]),
        .acc_o  (acc),
        .idx_o  (idx),
        .last_o (last)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            start_q  <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            bias_q   <= '0;
            result_q <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            ack_q   <= valid;
            dat_q   <= (valid && !wbs_we_i) ? rdata : '0;
            start_q <= 1'b0;
            if (wr && off == OFF_CTRL) begin
                irq_en_q <= wbs_dat_i[1];
                if (wbs_dat_i[2]) done_q <= 1'b0;
                if (wbs_dat_i[0] && !lock) start_q <= 1'b1;
            end
            if (wr && !lock) begin
                if (off == OFF_BIAS) bias_q <= wbs_dat_i[DATA_W-1:0];
                if (off[7:6] == REG_WEIGHT && in_rng) w_q[wi] <= wbs_dat_i[DATA_W-1:0];
                if (off[7:6] == REG_INPUT && in_rng) x_q[wi] <= wbs_dat_i[DATA_W-1:0];
            end
            // Later assignments win: START and FINISH override a same-cycle DONE_CLR.
            case (state_q)
                IDLE: if (start_q) begin
                    done_q  <= 1'b0;
                    state_q <= MAC;
                end
                MAC: if (last) state_q <= FINISH;
                FINISH: begin
                    result_q <= DATA_W'(sat(64'(acc >>> SHIFT), DATA_W, RELU));
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
